// File: rtl/player_motion_ctrl_if.sv
// Player motion control bus.
// Groups the key inputs, the bullet-spawn handshake and the position/tick outputs of
// player_motion_ctrl so that one bundle connects the block to its neighbours.
//   master : the motion controller itself.
//            It receives nums, shoot and fire_ack, and drives position, fire request and tick.
//   slave  : the opposite view, for the keyboard decoder, bullet pool or a testbench.
// Signals:
//   nums      [3]=up [2]=down [1]=left [0]=right, held-key levels
//   shoot     space held (level)
//   fire_ack  bullet pool accepted the spawn request (single-cycle pulse)
//   player_x  sprite left edge, pixels
//   player_y  sprite top edge, pixels
//   fire_req  spawn request, held until acknowledged
//   fire_x    spawn x, latched when the request is raised
//   fire_y    spawn y, latched when the request is raised
//   move_tick one-cycle pulse on every move tick
interface player_motion_ctrl_if;
  logic [3:0] nums;
  logic       shoot;
  logic       fire_ack;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       fire_req;
  logic [9:0] fire_x;
  logic [9:0] fire_y;
  logic       move_tick;

  modport master (
    input  nums,
    input  shoot,
    input  fire_ack,
    output player_x,
    output player_y,
    output fire_req,
    output fire_x,
    output fire_y,
    output move_tick
  );

  modport slave (
    output nums,
    output shoot,
    output fire_ack,
    input  player_x,
    input  player_y,
    input  fire_req,
    input  fire_x,
    input  fire_y,
    input  move_tick
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player motion controller.
// Moves the player sprite once per move tick from the held-key vector, clamped to the
// playfield, and raises bullet-spawn requests toward the bullet pool with a req/ack
// handshake. A tick-based cooldown after each accepted shot turns a held space key into
// auto-fire with a period of COOLDOWN move ticks.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active high
//   bus  player_motion_ctrl_if.master
//        in : nums, shoot, fire_ack
//        out: player_x, player_y, fire_req, fire_x, fire_y, move_tick
module player_motion_ctrl #(
  parameter int unsigned TICK_DIV = 1_666_666,  // clk cycles per move tick, >= 2
  parameter int unsigned STEP     = 4,          // pixels per tick per axis
  parameter int unsigned H_MAX    = 640,        // playfield width
  parameter int unsigned V_MAX    = 480,        // playfield height
  parameter int unsigned SPR_W    = 32,         // sprite width
  parameter int unsigned SPR_H    = 32,         // sprite height
  parameter int unsigned X_INIT   = 304,        // x after reset
  parameter int unsigned Y_INIT   = 440,        // y after reset
  parameter int unsigned COOLDOWN = 15          // move ticks between shots, >= 1
) (
  input  logic                 clk,
  input  logic                 rst,
  player_motion_ctrl_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(TICK_DIV);
  localparam int unsigned COOL_W = $clog2(COOLDOWN + 1);

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [9:0]        X_LIM     = 10'(H_MAX - SPR_W);
  localparam logic [9:0]        Y_LIM     = 10'(V_MAX - SPR_H);
  localparam logic [9:0]        X_RST     = 10'(X_INIT);
  localparam logic [9:0]        Y_RST     = 10'(Y_INIT);
  localparam logic [9:0]        HALF_W    = 10'(SPR_W / 2);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StCool
  } fire_state_e;

  // One axis step. Decrement saturates at 0; the increment is compared at 11 bits so a
  // position near the top of the 10-bit range cannot wrap before the clamp.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic dec,
                                           input logic inc, input logic [9:0] lim);
    logic [9:0] res;
    res = pos;
    if (dec && !inc) begin
      res = (pos < 10'(STEP)) ? 10'd0 : pos - 10'(STEP);
    end else if (inc && !dec) begin
      res = (({1'b0, pos} + 11'(STEP)) > {1'b0, lim}) ? lim : pos + 10'(STEP);
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------------------
  // Tick generation and movement
  // ---------------------------------------------------------------------------------------
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_hit;
  logic             move_tick_q;
  logic [9:0]       pos_x_q, pos_x_d;
  logic [9:0]       pos_y_q, pos_y_d;

  // tick_hit marks the edge on which move_tick is registered high; the position moves on
  // that same edge so player_x/player_y change in the cycle move_tick is visible.
  assign tick_hit = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_hit ? '0 : tick_cnt_q + CNT_W'(1);
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    if (tick_hit) begin
      pos_y_d = step_axis(pos_y_q, bus.nums[3], bus.nums[2], Y_LIM);
      pos_x_d = step_axis(pos_x_q, bus.nums[1], bus.nums[0], X_LIM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      move_tick_q <= 1'b0;
      pos_x_q     <= X_RST;
      pos_y_q     <= Y_RST;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      move_tick_q <= tick_hit;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Fire FSM
  // ---------------------------------------------------------------------------------------
  fire_state_e       state_q, state_d;
  logic [COOL_W-1:0] cool_cnt_q, cool_cnt_d;
  logic [9:0]        fire_x_q, fire_x_d;
  logic [9:0]        fire_y_q, fire_y_d;
  logic              fire_req;

  // State register, including the data captured alongside state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cool_cnt_q <= '0;
      fire_x_q   <= '0;
      fire_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      cool_cnt_q <= cool_cnt_d;
      fire_x_q   <= fire_x_d;
      fire_y_q   <= fire_y_d;
    end
  end

  // Next state. The spawn point is captured only when leaving IDLE, so it stays frozen
  // while the request waits even though the player keeps moving.
  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    fire_x_d   = fire_x_q;
    fire_y_d   = fire_y_q;
    unique case (state_q)
      StIdle: begin
        if (bus.shoot) begin
          state_d  = StReq;
          fire_x_d = pos_x_q + HALF_W;
          fire_y_d = pos_y_q;
        end
      end
      StReq: begin
        // Releasing shoot does not cancel; only the ack ends the request.
        if (bus.fire_ack) begin
          state_d    = StCool;
          cool_cnt_d = COOL_LOAD;
        end
      end
      StCool: begin
        if (move_tick_q) begin
          cool_cnt_d = cool_cnt_q - COOL_W'(1);
          if (cool_cnt_q <= COOL_W'(1)) begin
            state_d    = StIdle;
            cool_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    fire_req = (state_q == StReq);
  end

  assign bus.player_x  = pos_x_q;
  assign bus.player_y  = pos_y_q;
  assign bus.move_tick = move_tick_q;
  assign bus.fire_req  = fire_req;
  assign bus.fire_x    = fire_x_q;
  assign bus.fire_y    = fire_y_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed testbench for player_motion_ctrl with TICK_DIV=4, STEP=4, COOLDOWN=2.
module tb_player_motion_ctrl;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  player_motion_ctrl_if bus ();

  player_motion_ctrl #(
    .TICK_DIV (4),
    .STEP     (4),
    .H_MAX    (640),
    .V_MAX    (480),
    .SPR_W    (32),
    .SPR_H    (32),
    .X_INIT   (304),
    .Y_INIT   (440),
    .COOLDOWN (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Advance to the next negedge at which move_tick is high.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.move_tick && n < 32);
    checks++;
    if (bus.move_tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_timeout: move_tick=%b after %0d cycles, required 1", bus.move_tick, n);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.nums     = 4'b0000;
    bus.shoot    = 1'b0;
    bus.fire_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.player_x !== 10'd304) begin
      errors++; $display("FAIL reset_x: got %0d, required 304", bus.player_x);
    end
    checks++;
    if (bus.player_y !== 10'd440) begin
      errors++; $display("FAIL reset_y: got %0d, required 440", bus.player_y);
    end
    checks++;
    if (bus.fire_req !== 1'b0) begin
      errors++; $display("FAIL reset_fire_req: got %b, required 0", bus.fire_req);
    end
    checks++;
    if (bus.move_tick !== 1'b0) begin
      errors++; $display("FAIL reset_move_tick: got %b, required 0", bus.move_tick);
    end
    checks++;
    if (bus.fire_x !== 10'd0 || bus.fire_y !== 10'd0) begin
      errors++;
      $display("FAIL reset_fire_xy: got %0d/%0d, required 0/0", bus.fire_x, bus.fire_y);
    end
    rst = 1'b0;
  endtask

  // Released at a negedge with tick_cnt=0: pulses expected at negedges 4, 8, 12, 16.
  task automatic test_tick();
    int first, last, cnt, adjacent;
    logic prev;
    first = -1; last = -1; cnt = 0; adjacent = 0; prev = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus.move_tick === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
        if (prev) adjacent++;
      end
      prev = bus.move_tick;
    end
    checks++;
    if (cnt != 4) begin
      errors++; $display("FAIL tick_count: got %0d pulses, required 4", cnt);
    end
    checks++;
    if (first != 4 || last != 16) begin
      errors++; $display("FAIL tick_phase: first/last %0d/%0d, required 4/16", first, last);
    end
    checks++;
    if (adjacent != 0) begin
      errors++; $display("FAIL tick_width: %0d wide pulses, required 0", adjacent);
    end
  endtask

  task automatic test_move_right();
    bus.nums = 4'b0001;
    ticks(3);
    bus.nums = 4'b0000;
    checks++;
    if (bus.player_x !== 10'd316 || bus.player_y !== 10'd440) begin
      errors++;
      $display("FAIL move_right: got %0d,%0d, required 316,440", bus.player_x, bus.player_y);
    end
  endtask

  task automatic test_clamp_down();
    int exp_y[3] = '{444, 448, 448};
    bus.nums = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      checks++;
      if (bus.player_y !== 10'(exp_y[i])) begin
        errors++;
        $display("FAIL clamp_down[%0d]: got %0d, required %0d", i, bus.player_y, exp_y[i]);
      end
    end
    bus.nums = 4'b0000;
  endtask

  task automatic test_conflict();
    bus.nums = 4'b1111;
    ticks(5);
    bus.nums = 4'b0000;
    checks++;
    if (bus.player_x !== 10'd316 || bus.player_y !== 10'd448) begin
      errors++;
      $display("FAIL conflict: got %0d,%0d, required 316,448", bus.player_x, bus.player_y);
    end
  endtask

  task automatic test_diagonal();
    bus.nums = 4'b1001;
    wait_tick();
    bus.nums = 4'b0000;
    checks++;
    if (bus.player_x !== 10'd320 || bus.player_y !== 10'd444) begin
      errors++;
      $display("FAIL diagonal: got %0d,%0d, required 320,444", bus.player_x, bus.player_y);
    end
  endtask

  // Left from 320: 79 ticks -> 4, 80 -> 0, 81 holds at 0.
  task automatic test_clamp_left();
    bus.nums = 4'b0010;
    ticks(79);
    checks++;
    if (bus.player_x !== 10'd4) begin
      errors++; $display("FAIL clamp_left_pre: got %0d, required 4", bus.player_x);
    end
    wait_tick();
    checks++;
    if (bus.player_x !== 10'd0) begin
      errors++; $display("FAIL clamp_left_zero: got %0d, required 0", bus.player_x);
    end
    wait_tick();
    checks++;
    if (bus.player_x !== 10'd0) begin
      errors++; $display("FAIL clamp_left_hold: got %0d, required 0", bus.player_x);
    end
    bus.nums = 4'b0000;
  endtask

  // Up from 444: 111 ticks -> 0, one more holds; then 10 ticks down -> 40.
  task automatic test_clamp_up();
    bus.nums = 4'b1000;
    ticks(112);
    checks++;
    if (bus.player_y !== 10'd0) begin
      errors++; $display("FAIL clamp_up: got %0d, required 0", bus.player_y);
    end
    bus.nums = 4'b0100;
    ticks(10);
    bus.nums = 4'b0000;
    checks++;
    if (bus.player_y !== 10'd40) begin
      errors++; $display("FAIL down_after_up: got %0d, required 40", bus.player_y);
    end
  endtask

  // Right from 0: 151 ticks -> 604, 152 -> 608, 153 holds at 608.
  task automatic test_clamp_right();
    bus.nums = 4'b0001;
    ticks(151);
    checks++;
    if (bus.player_x !== 10'd604) begin
      errors++; $display("FAIL clamp_right_pre: got %0d, required 604", bus.player_x);
    end
    ticks(2);
    checks++;
    if (bus.player_x !== 10'd608) begin
      errors++; $display("FAIL clamp_right_hold: got %0d, required 608", bus.player_x);
    end
    bus.nums = 4'b0000;
  endtask

  // Entered at a tick negedge T with x=608, y=40; later ticks land at T+4, T+8, T+12.
  task automatic test_handshake();
    int bad;
    bus.shoot = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fire_req !== 1'b1 || bus.fire_x !== 10'd624 || bus.fire_y !== 10'd40) begin
      errors++;
      $display("FAIL req_raise: req=%b x=%0d y=%0d, required 1/624/40",
               bus.fire_req, bus.fire_x, bus.fire_y);
    end
    // Release shoot and move left while waiting: request and spawn point must stay put.
    bus.shoot = 1'b0;
    bus.nums  = 4'b0010;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.fire_req !== 1'b1 || bus.fire_x !== 10'd624 || bus.fire_y !== 10'd40) bad++;
    end
    bus.nums = 4'b0000;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL req_hold: %0d bad cycles, required 0", bad);
    end
    checks++;
    if (bus.player_x !== 10'd600) begin
      errors++; $display("FAIL move_during_req: got %0d, required 600", bus.player_x);
    end
    bus.fire_ack = 1'b1;
    @(negedge clk);
    bus.fire_ack = 1'b0;
    checks++;
    if (bus.fire_req !== 1'b0) begin
      errors++; $display("FAIL req_drop: got %b, required 0", bus.fire_req);
    end
  endtask

  task automatic test_auto_fire();
    int n, nt;
    ticks(3);  // let the previous cooldown expire
    bus.shoot = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fire_req !== 1'b1 || bus.fire_x !== 10'd616) begin
      errors++;
      $display("FAIL auto_first: req=%b x=%0d, required 1/616", bus.fire_req, bus.fire_x);
    end
    for (int r = 0; r < 2; r++) begin
      bus.fire_ack = 1'b1;
      @(negedge clk);
      bus.fire_ack = 1'b0;
      checks++;
      if (bus.fire_req !== 1'b0) begin
        errors++; $display("FAIL auto_drop[%0d]: got %b, required 0", r, bus.fire_req);
      end
      n = 0; nt = 0;
      while (bus.fire_req !== 1'b1 && n < 40) begin
        if (bus.move_tick === 1'b1) nt++;
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus.fire_req !== 1'b1 || nt != 2) begin
        errors++;
        $display("FAIL auto_period[%0d]: req=%b after %0d ticks, required 1 after 2",
                 r, bus.fire_req, nt);
      end
    end
    // Leaves a request pending for the reset test.
  endtask

  task automatic test_reset_mid_req();
    int bad;
    checks++;
    if (bus.fire_req !== 1'b1) begin
      errors++; $display("FAIL pre_reset_req: got %b, required 1", bus.fire_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.fire_req !== 1'b0 || bus.player_x !== 10'd304 || bus.player_y !== 10'd440) begin
      errors++;
      $display("FAIL async_reset: req=%b x=%0d y=%0d, required 0/304/440",
               bus.fire_req, bus.player_x, bus.player_y);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.shoot = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.fire_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL no_pending_shot: %0d cycles with req, required 0", bad);
    end
    bus.shoot = 1'b1;
    @(negedge clk);
    bus.shoot = 1'b0;
    checks++;
    if (bus.fire_req !== 1'b1 || bus.fire_x !== 10'd320 || bus.fire_y !== 10'd440) begin
      errors++;
      $display("FAIL restart_idle: req=%b x=%0d y=%0d, required 1/320/440",
               bus.fire_req, bus.fire_x, bus.fire_y);
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_move_right();
    test_clamp_down();
    test_conflict();
    test_diagonal();
    test_clamp_left();
    test_clamp_up();
    test_clamp_right();
    test_handshake();
    test_auto_fire();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
